// File: rtl/engine_dimm_sieve_configure_request.sv
// Configuration-window fetch engine: issues one read per word of this engine's
// window, tracks in-flight reads and pulses done when every response is back.
module engine_dimm_sieve_configure_request #(
  parameter int ID_RELATIVE      = 0,
  parameter int ENGINE_SEQ_WIDTH = 16,
  parameter int ENGINE_SEQ_MIN   = ID_RELATIVE * ENGINE_SEQ_WIDTH,
  parameter int WORD_BYTES       = 4,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic        ap_clk,
  input  logic        areset_n,
  input  logic        start,
  input  logic [63:0] base_address,
  input  logic [4:0]  num_words,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_address,
  output logic [15:0] req_offset,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_offset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam logic [4:0]  SEQ_WIDTH_W  = 5'(ENGINE_SEQ_WIDTH);
  localparam logic [15:0] SEQ_MIN_W    = 16'(ENGINE_SEQ_MIN);
  localparam logic [15:0] SEQ_SPAN_W   = 16'(ENGINE_SEQ_WIDTH);
  localparam logic [3:0]  MAX_OUT_W    = 4'(MAX_OUTSTANDING);
  localparam logic [63:0] WORD_BYTES_W = 64'(WORD_BYTES);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  n_q, n_d;
  logic [63:0] base_q, base_d;
  logic [3:0]  out_q, out_d;
  logic [4:0]  rcv_q, rcv_d;
  logic [63:0] req_address_q, req_address_d;
  logic [15:0] req_offset_q, req_offset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [4:0]  n_start;
  logic [16:0] rsp_rel;
  logic        rsp_in_window;
  logic        hs;
  logic        accept;
  logic        rsp_hit;
  logic        rsp_count;
  logic        rsp_stray;

  assign n_start = (num_words == 5'd0 || num_words > SEQ_WIDTH_W) ? SEQ_WIDTH_W : num_words;

  // A response below the window borrows into bit 16 of the 17-bit difference.
  assign rsp_rel       = {1'b0, rsp_offset} - {1'b0, SEQ_MIN_W};
  assign rsp_in_window = !rsp_rel[16] && (rsp_rel[15:0] < SEQ_SPAN_W);

  assign req_valid = (state_q == ISSUE) && (idx_q < n_q) && (out_q < MAX_OUT_W);
  assign hs        = req_valid && req_ready;
  assign accept    = (state_q == IDLE) && start;
  assign rsp_hit   = rsp_valid && rsp_in_window;
  assign rsp_count = rsp_hit && ((out_q != 4'd0) || hs);
  assign rsp_stray = rsp_hit && (out_q == 4'd0) && !hs;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    idx_d         = idx_q;
    n_d           = n_q;
    base_d        = base_q;
    out_d         = out_q;
    rcv_d         = rcv_q;
    req_offset_d  = req_offset_q;
    req_address_d = req_address_q;
    error_d       = error_q | rsp_stray;

    if (hs) idx_d = idx_q + 5'd1;

    case ({hs, rsp_count})
      2'b10:   if (out_q != 4'hF) out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    if (rsp_count && rcv_q != 5'h1F) rcv_d = rcv_q + 5'd1;

    if (accept) begin
      idx_d  = 5'd0;
      n_d    = n_start;
      base_d = base_address;
      out_d  = 4'd0;
      rcv_d  = 5'd0;
    end

    // Request fields only move on a new fetch or a handshake, so they hold while stalled.
    if (accept || hs) begin
      req_offset_d  = SEQ_MIN_W + {11'd0, idx_d};
      req_address_d = base_d + ({48'd0, req_offset_d} * WORD_BYTES_W);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (hs && (idx_q + 5'd1 == n_q)) state_d = DRAIN;
      DRAIN:   if (out_d == 4'd0 && rcv_d == n_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      idx_q         <= 5'd0;
      n_q           <= 5'd0;
      base_q        <= 64'd0;
      out_q         <= 4'd0;
      rcv_q         <= 5'd0;
      req_address_q <= 64'd0;
      req_offset_q  <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      n_q           <= n_d;
      base_q        <= base_d;
      out_q         <= out_d;
      rcv_q         <= rcv_d;
      req_address_q <= req_address_d;
      req_offset_q  <= req_offset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign req_address = req_address_q;
  assign req_offset  = req_offset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_engine_dimm_sieve_configure_request.sv
// Directed bench: two engine instances (window 0 with two in-flight reads, window 1
// with four) share stimulus; a small request/response model predicts every output.
module tb_engine_dimm_sieve_configure_request;

  logic        ap_clk;
  logic        areset_n;
  logic        start_a, start_b;
  logic [63:0] base_address;
  logic [4:0]  num_words;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_offset;

  logic        rv0, rv1, bz0, bz1, dn0, dn1, er0, er1;
  logic [63:0] ra0, ra1;
  logic [15:0] ro0, ro1;

  logic        sel;
  logic        rv, bz, dn, er;
  logic [63:0] ra;
  logic [15:0] ro;

  int n_vec  = 0;
  int n_miss = 0;

  engine_dimm_sieve_configure_request #(.ID_RELATIVE(0), .MAX_OUTSTANDING(2)) u_dut0 (
    .ap_clk(ap_clk), .areset_n(areset_n), .start(start_a),
    .base_address(base_address), .num_words(num_words),
    .req_valid(rv0), .req_ready(req_ready), .req_address(ra0), .req_offset(ro0),
    .rsp_valid(rsp_valid), .rsp_offset(rsp_offset),
    .busy(bz0), .done(dn0), .error(er0)
  );

  engine_dimm_sieve_configure_request #(.ID_RELATIVE(1), .MAX_OUTSTANDING(4)) u_dut1 (
    .ap_clk(ap_clk), .areset_n(areset_n), .start(start_b),
    .base_address(base_address), .num_words(num_words),
    .req_valid(rv1), .req_ready(req_ready), .req_address(ra1), .req_offset(ro1),
    .rsp_valid(rsp_valid), .rsp_offset(rsp_offset),
    .busy(bz1), .done(dn1), .error(er1)
  );

  assign rv = sel ? rv1 : rv0;
  assign bz = sel ? bz1 : bz0;
  assign dn = sel ? dn1 : dn0;
  assign er = sel ? er1 : er0;
  assign ra = sel ? ra1 : ra0;
  assign ro = sel ? ro1 : ro0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input bit s, input bit v);
    start_a = !s && v;
    start_b = s && v;
  endtask

  task automatic check_zero(input bit s);
    sel = s;
    #1;
    check("zero_req_valid", rv, 0);
    check("zero_busy", bz, 0);
    check("zero_done", dn, 0);
    check("zero_error", er, 0);
    check("zero_req_address", ra, 0);
    check("zero_req_offset", ro, 0);
  endtask

  // One complete fetch; responses return lat cycles after each handshake, in order.
  task automatic run_fetch(input bit s, input logic [63:0] base, input logic [4:0] nw,
                           input int exp_n, input int lat, input bit toggle,
                           input int restart_cyc, input int exp_done_cyc);
    int min_off, max_out, hs, rcv, outst, last_rsp, done_cyc;
    int due_cyc[$];
    int due_off[$];
    bit exp_valid, exp_done, fire, stalled, finished;
    logic [15:0] stall_off;
    logic [63:0] stall_addr;
    min_off  = s ? 16 : 0;
    max_out  = s ? 4 : 2;
    hs = 0; rcv = 0; outst = 0; last_rsp = -10; done_cyc = -1;
    stalled = 1'b0; finished = 1'b0;
    stall_off = '0; stall_addr = '0;
    sel = s;
    tick();
    base_address = base;
    num_words    = nw;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    drive_start(s, 1'b1);
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      tick();
      drive_start(s, cyc == restart_cyc);
      if (cyc == restart_cyc) num_words = 5'd1;
      req_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      exp_valid = (hs < exp_n) && (outst < max_out);
      exp_done  = (rcv == exp_n) && (cyc == last_rsp + 1);
      check("req_valid", rv, exp_valid);
      check("busy", bz, 1);
      check("done", dn, exp_done);
      if (stalled) begin
        check("stall_offset", ro, stall_off);
        check("stall_address", ra, stall_addr);
      end
      if (rv) begin
        check("req_offset", ro, 16'(min_off + hs));
        check("req_address", ra, base + 64'((min_off + hs) * 4));
      end
      fire       = rv && req_ready;
      stalled    = rv && !req_ready;
      stall_off  = ro;
      stall_addr = ra;
      rsp_valid  = 1'b0;
      if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
        void'(due_cyc.pop_front());
        rsp_valid  = 1'b1;
        rsp_offset = 16'(due_off.pop_front());
        rcv++;
        outst--;
        last_rsp = cyc;
      end
      if (fire) begin
        due_cyc.push_back(cyc + lat);
        due_off.push_back(min_off + hs);
        hs++;
        outst++;
      end
      if (exp_done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
    end
    tick();
    rsp_valid = 1'b0;
    check("fetch_finished", finished, 1);
    check("handshake_count", hs, exp_n);
    check("done_after", dn, 0);
    check("busy_after", bz, 0);
    check("req_valid_after", rv, 0);
    if (exp_done_cyc >= 0) check("done_cycle", done_cyc, exp_done_cyc);
  endtask

  initial begin
    areset_n = 1'b0;
    sel = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    base_address = '0; num_words = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_offset = '0;

    // Reset state of both engines.
    #2;
    check_zero(1'b0);
    check_zero(1'b1);
    tick();
    tick();
    areset_n = 1'b1;
    tick();

    // Window 1, six words, ready tied high, 3-cycle response latency: done at cycle 10.
    run_fetch(1'b1, 64'h1000, 5'd6, 6, 3, 1'b0, -1, 10);

    // num_words = 0 means the full window of 16 (window 0, two in flight).
    run_fetch(1'b0, 64'h0, 5'd0, 16, 2, 1'b0, -1, -1);

    // num_words = 20 clamps to 16; base near the top of the address space wraps.
    run_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 5'd20, 16, 1, 1'b0, -1, 18);

    // Alternating ready with responses landing on handshake cycles; a start while busy is ignored.
    run_fetch(1'b0, 64'h3000, 5'd5, 5, 2, 1'b1, 2, -1);

    // Two in flight, responses withheld, then released out of order.
    sel = 1'b0;
    tick();
    base_address = 64'h2000; num_words = 5'd3; req_ready = 1'b1; rsp_valid = 1'b0;
    drive_start(1'b0, 1'b1);
    tick();                                   // cycle 1
    drive_start(1'b0, 1'b0);
    check("cap_c1_valid", rv, 1);
    check("cap_c1_offset", ro, 16'd0);
    check("cap_c1_address", ra, 64'h2000);
    tick();                                   // cycle 2
    check("cap_c2_valid", rv, 1);
    check("cap_c2_offset", ro, 16'd1);
    check("cap_c2_address", ra, 64'h2004);
    tick();                                   // cycle 3
    check("cap_c3_valid", rv, 0);
    tick();                                   // cycle 4
    check("cap_c4_valid", rv, 0);
    tick();                                   // cycle 5
    check("cap_c5_valid", rv, 0);
    rsp_valid = 1'b1; rsp_offset = 16'd0;
    tick();                                   // cycle 6
    rsp_valid = 1'b0;
    check("cap_c6_valid", rv, 1);
    check("cap_c6_offset", ro, 16'd2);
    check("cap_c6_address", ra, 64'h2008);
    tick();                                   // cycle 7
    check("cap_c7_valid", rv, 0);
    check("cap_c7_busy", bz, 1);
    tick();                                   // cycle 8
    rsp_valid = 1'b1; rsp_offset = 16'd2;
    check("cap_c8_done", dn, 0);
    tick();                                   // cycle 9
    rsp_offset = 16'd1;
    check("cap_c9_done", dn, 0);
    tick();                                   // cycle 10
    rsp_valid = 1'b0;
    check("cap_c10_done", dn, 1);
    check("cap_c10_busy", bz, 1);
    tick();                                   // cycle 11
    check("cap_c11_done", dn, 0);
    check("cap_c11_busy", bz, 0);
    check("cap_c11_error", er, 0);

    // Reset pulsed while window 1 is draining abandons the fetch.
    sel = 1'b1;
    tick();
    base_address = 64'h8000; num_words = 5'd4; req_ready = 1'b1;
    drive_start(1'b1, 1'b1);
    tick();
    drive_start(1'b1, 1'b0);
    repeat (4) tick();                        // handshakes in cycles 1..4, draining from 5
    check("drain_valid", rv, 0);
    check("drain_busy", bz, 1);
    areset_n = 1'b0;
    check_zero(1'b1);
    tick();
    areset_n = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_offset = 16'd40;
    tick();
    check("post_reset_oow_error", er, 0);
    rsp_offset = 16'd17;
    tick();
    rsp_valid = 1'b0;
    check("post_reset_stray_error", er, 1);
    check("post_reset_done", dn, 0);
    check("post_reset_busy", bz, 0);
    run_fetch(1'b1, 64'h8000, 5'd2, 2, 1, 1'b0, -1, 4);

    // Stray responses to idle window 0.
    sel = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_offset = 16'd40;
    tick();
    check("idle_oow_error", er, 0);
    rsp_offset = 16'd5;
    tick();
    rsp_valid = 1'b0;
    check("idle_stray_error", er, 1);
    check("idle_stray_done", dn, 0);
    check("idle_stray_busy", bz, 0);
    rsp_valid = 1'b1; rsp_offset = 16'd40;
    tick();
    rsp_valid = 1'b0;
    check("idle_sticky_error", er, 1);
    tick();
    check("idle_sticky_error2", er, 1);
    check("idle_sticky_done", dn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/engine_dimm_sieve_configure_request.md
ENGINE_DIMM_SIEVE_CONFIGURE_REQUEST -- requirements
Module: engine_dimm_sieve_configure_request

Interface
REQ-001 Parameter ID_RELATIVE, default 0, selects this engine's configuration window.
REQ-002 Parameter ENGINE_SEQ_WIDTH, default 16, gives the number of words in one configuration window.
REQ-003 Parameter ENGINE_SEQ_MIN, default ID_RELATIVE*ENGINE_SEQ_WIDTH, is the first word offset of the window.
REQ-004 Parameter WORD_BYTES, default 4, gives bytes per configuration word.
REQ-005 Parameter MAX_OUTSTANDING, default 4, caps in-flight reads; legal range 1..15.
REQ-006 The ports SHALL be, in order:
- ap_clk  in  1  the only clock.
- areset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a fetch.
- base_address  in  64  byte address of offset 0; sampled on the accepted start.
- num_words  in  5  words to fetch; sampled on start; 0 means ENGINE_SEQ_WIDTH; values above ENGINE_SEQ_WIDTH are clamped to it.
- req_valid  out  1  read request valid.
- req_ready  in  1  downstream accepts the request.
- req_address  out  64  byte address of the request.
- req_offset  out  16  word offset (meta.address.offset) of the request.
- rsp_valid  in  1  a read response has arrived.
- rsp_offset  in  16  offset carried by that response.
- busy  out  1  a fetch is in progress.
- done  out  1  one-cycle pulse when every response of the fetch is back.
- error  out  1  sticky flag: an in-window response arrived while nothing was outstanding.

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN in the cycle the last request handshakes.
- DRAIN -> DONE when the outstanding count reaches 0 and the received count equals N.
- DONE -> IDLE after one cycle.
REQ-008 While busy, start SHALL be ignored and SHALL not be queued.
REQ-009 In IDLE, a start also sets the issue index i to 0, the received count to 0 and the outstanding count to 0.
REQ-010 In ISSUE, req_valid SHALL be 1 exactly when i < N and outstanding < MAX_OUTSTANDING.
- req_offset = ENGINE_SEQ_MIN + i.
- req_address = base_address + (ENGINE_SEQ_MIN + i)*WORD_BYTES, modulo 2^64.
REQ-011 Once req_valid is asserted, it and the request fields SHALL stay stable until req_ready is seen.
- Each handshake (req_valid & req_ready) increments i.
REQ-012 Requests SHALL issue strictly in offset order, one per cycle at most; with no backpressure there are no bubbles.
REQ-013 Outstanding SHALL increment on each handshake and decrement on each counted response.
- A handshake and a response in the same cycle leave outstanding unchanged.
REQ-014 A response is counted only when rsp_valid is 1, rsp_offset is in [ENGINE_SEQ_MIN, ENGINE_SEQ_MIN+ENGINE_SEQ_WIDTH), and outstanding > 0 (or a handshake occurs in the same cycle).
- An out-of-window response SHALL be ignored silently.
- An in-window response while outstanding = 0 and no handshake is occurring SHALL set error, and SHALL change no counter.
- Responses may return in any order.
REQ-015 Counters SHALL saturate and never wrap.
- outstanding: 4 bits.
- received: 5 bits.
REQ-016 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-017 done SHALL assert for exactly one cycle, in the DONE state.
- Start-to-done latency with req_ready always 1 and responses returned L cycles after each request is N + L + 1 cycles.
REQ-018 Outputs SHALL be registered except req_valid, which may be combinational from the state, the counters and i.

Reset
REQ-019 While areset_n = 0, the following SHALL hold asynchronously:
- state = IDLE.
- req_valid = 0, busy = 0, done = 0, error = 0.
- req_address = 0, req_offset = 0.
- all counters = 0.
REQ-020 Reset asserted mid-fetch SHALL abandon the fetch; responses arriving after reset is released, with nothing outstanding, set error only if they are in-window.
REQ-021 Reset release SHALL take effect on the first ap_clk edge after deassertion; no start is accepted before that edge.

Verification
REQ-022 ID_RELATIVE=1, base=0x1000, num_words=6, ready tied 1, responses 3 cycles later -> offsets 16..21, addresses 0x1040..0x1054 step 4, done at cycle 10 after start.
REQ-023 num_words=0 -> exactly 16 requests (offsets 0..15) before done; num_words=20 -> clamped to 16.
REQ-024 MAX_OUTSTANDING=2, responses withheld -> req_valid drops after 2 handshakes; one response -> exactly one more request issues.
REQ-025 req_ready toggled 1010..., with a response and a handshake in the same cycle -> fields stable while stalled, outstanding unchanged in that cycle, no duplicate or skipped offset.
REQ-026 Stray rsp_offset=5 (in window, ID_RELATIVE=0) in IDLE -> error=1 sticky, no done; rsp_offset=40 -> ignored, error unchanged.
REQ-027 areset_n pulsed low during DRAIN -> outputs zero immediately; a new start after release completes normally.
